dmem_port_arbiter: RTL

- Shares the single-port 256-word data RAM between two requesters: the pipeline MEM stage (port P) and the program/debug loader (port L).
- Sequences the RAM's one-cycle read latency and returns read data to the correct owner.
- Produces the pipeline stall when P cannot be serviced.
- Sits between the MEM/WB datapath and the RAM macro; the RAM clocking arrangement is unchanged.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_port_arbiter_if.sv | 48 ++++
 rtl/dmem_arb_starve_ctr.sv | 35 +++
 rtl/dmem_port_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory port arbiter.
// The optional performance counters are controlled by the DMEM_ARB_PERF_EN macro in the top.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P_RESP = 2'd1,
        L_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_L = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 4;
    localparam int WAIT_W       = 4;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the pipeline MEM stage (P), the loader (L), the arbiter and the RAM macro.
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // Handshake: x_req/x_we/x_addr/x_wdata are held stable until x_done; x_done is a
    // single-cycle pulse that completes the access (x_rdata is valid with it on reads).
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_done;
    logic [DATA_W-1:0] p_rdata;
    logic              p_stall;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_done;
    logic [DATA_W-1:0] l_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_done, p_rdata, p_stall,
        input  l_req, l_we, l_addr, l_wdata,
        output l_done, l_rdata,
        output ram_addr, ram_data, ram_wren,
        input  ram_q
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_done, p_rdata, p_stall,
        output l_req, l_we, l_addr, l_wdata,
        input  l_done, l_rdata,
        input  ram_addr, ram_data, ram_wren,
        output ram_q
    );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the loader was eligible, requesting and lost;
// o_force_l asks the arbiter to let the loader win once the count reaches MAX_WAIT.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_l_elig,
    input  logic              i_l_req,
    input  logic              i_l_issue,
    output logic              o_force_l,
    output logic [WAIT_W-1:0] o_wait_cnt
);

    localparam logic [WAIT_W-1:0] W_MAX = MAX_WAIT[WAIT_W-1:0];

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_l_issue || !i_l_req) begin
            r_cnt <= '0;
        end else if (i_l_elig && (r_cnt != W_MAX)) begin
            // Eligible, requesting and not issued means it lost this cycle.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force_l  = (r_cnt == W_MAX);
    assign o_wait_cnt = r_cnt;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the pipeline (P) and the loader (L).
// Define DMEM_ARB_PERF_EN to build the P-stall and L-grant performance counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    dmem_port_arbiter_if.slave bus,
    output logic [31:0]       perf_p_stall_cnt,
    output logic [31:0]       perf_l_grant_cnt,
    output state_t            o_dbg_state,
    output logic [WAIT_W-1:0] o_dbg_wait_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            w_owner;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic [DATA_W-1:0] r_p_rdata;
    logic [DATA_W-1:0] r_l_rdata;
    logic              w_p_cand;
    logic              w_l_cand;
    logic              w_l_elig;
    logic              w_issue_p;
    logic              w_issue_l;
    logic              w_force_l;
    logic              w_p_resp;
    logic              w_l_resp;
    logic              w_p_done;
    logic              w_l_done;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_data;
    logic              w_ram_wren;

    // A requester cannot be issued in the cycle its own read response is returned.
    assign w_l_elig  = (r_state != L_RESP);
    assign w_p_cand  = !rst && bus.p_req && (r_state != P_RESP);
    assign w_l_cand  = !rst && bus.l_req && w_l_elig;
    assign w_issue_l = w_l_cand && (w_force_l || !w_p_cand);
    assign w_issue_p = w_p_cand && !w_issue_l;
    assign w_owner   = w_issue_l ? OWN_L : OWN_P;
    assign w_p_resp  = !rst && (r_state == P_RESP);
    assign w_l_resp  = !rst && (r_state == L_RESP);

    dmem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_l_elig   (w_l_elig),
        .i_l_req    (bus.l_req),
        .i_l_issue  (w_issue_l),
        .o_force_l  (w_force_l),
        .o_wait_cnt (o_dbg_wait_cnt)
    );

    always_comb begin
        w_state_nxt = IDLE;
        w_ram_addr  = r_ram_addr;
        w_ram_data  = r_ram_data;
        w_ram_wren  = 1'b0;
        if (w_issue_p || w_issue_l) begin
            if (w_owner == OWN_L) begin
                w_ram_addr = bus.l_addr;
                w_ram_data = bus.l_wdata;
                w_ram_wren = bus.l_we;
            end else begin
                w_ram_addr = bus.p_addr;
                w_ram_data = bus.p_wdata;
                w_ram_wren = bus.p_we;
            end
        end
        if (w_issue_p && !bus.p_we) begin
            w_state_nxt = P_RESP;
        end else if (w_issue_l && !bus.l_we) begin
            w_state_nxt = L_RESP;
        end
        w_p_done = w_p_resp || (w_issue_p && bus.p_we);
        w_l_done = w_l_resp || (w_issue_l && bus.l_we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_p_rdata  <= '0;
            r_l_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue_p || w_issue_l) begin
                r_ram_addr <= w_ram_addr;
                r_ram_data <= w_ram_data;
            end
            if (w_p_resp) begin
                r_p_rdata <= bus.ram_q;
            end
            if (w_l_resp) begin
                r_l_rdata <= bus.ram_q;
            end
        end
    end

    assign bus.ram_addr = w_ram_addr;
    assign bus.ram_data = w_ram_data;
    assign bus.ram_wren = w_ram_wren;
    assign bus.p_done   = w_p_done;
    assign bus.l_done   = w_l_done;
    assign bus.p_rdata  = w_p_resp ? bus.ram_q : r_p_rdata;
    assign bus.l_rdata  = w_l_resp ? bus.ram_q : r_l_rdata;
    assign bus.p_stall  = bus.p_req && !w_p_done;
    assign o_dbg_state  = r_state;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_p_stall;
    logic [31:0] r_perf_l_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_p_stall <= '0;
            r_perf_l_grant <= '0;
        end else begin
            if (bus.p_stall) begin
                r_perf_p_stall <= r_perf_p_stall + 32'd1;
            end
            if (w_issue_l) begin
                r_perf_l_grant <= r_perf_l_grant + 32'd1;
            end
        end
    end

    assign perf_p_stall_cnt = r_perf_p_stall;
    assign perf_l_grant_cnt = r_perf_l_grant;
`else
    assign perf_p_stall_cnt = 32'd0;
    assign perf_l_grant_cnt = 32'd0;
`endif

    // A requester whose read is in flight must keep its request up until the response.
    a_p_hold : assert property (@(posedge clk) disable iff (rst) (r_state == P_RESP) |-> bus.p_req);
    a_l_hold : assert property (@(posedge clk) disable iff (rst) (r_state == L_RESP) |-> bus.l_req);

endmodule
